// File: rtl/obstacle_scheduler_pkg.sv
// Shared game package: scheduler state encoding, lane width and lane LFSR constants,
// plus the level-controller state type the racing levels already use.
package obstacle_scheduler_pkg;

    typedef logic [1:0] sched_state_t;

    localparam sched_state_t ST_IDLE  = 2'd0;
    localparam sched_state_t ST_MOVE  = 2'd1;
    localparam sched_state_t ST_SPAWN = 2'd2;

    localparam int LANE_W = 2;

    // x^8 + x^6 + x^5 + x^4 + 1, shifting toward bit 7
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [1:0] {
        LVL_ATTRACT,
        LVL_RUN,
        LVL_CRASH,
        LVL_DONE
    } level_state_t;

endpackage

// File: rtl/obstacle_lane_gen.sv
// Lane source for new obstacles. OBSTACLE_LANE_RAND_EN selects an 8-bit Fibonacci LFSR;
// otherwise a round-robin counter. Advances once per accepted frame.
module obstacle_lane_gen
    import obstacle_scheduler_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              step,
    output logic [LANE_W-1:0] lane
);

`ifdef OBSTACLE_LANE_RAND_EN
    logic [7:0] lfsr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr <= LFSR_SEED;
        end else if (step) begin
            lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
        end
    end

    assign lane = lfsr[LANE_W-1:0];
`else
    logic [LANE_W-1:0] lane_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane_cnt <= '0;
        end else if (step) begin
            lane_cnt <= lane_cnt + LANE_W'(1);
        end
    end

    assign lane = lane_cnt;
`endif

endmodule

// File: rtl/obstacle_scheduler.sv
// Per-frame obstacle pool: moves active slots left, then spawns into the lowest free slot.
// Lane source chosen by OBSTACLE_LANE_RAND_EN (see obstacle_lane_gen).
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for frame_tick; lane generator steps on an accepted tick
// ST_MOVE  | one slot per cycle, idx 0..NUM_SLOTS-1, x -= speed or free slot
// ST_SPAWN | timer countdown or spawn into lowest free slot, back to ST_IDLE
module obstacle_scheduler
    import obstacle_scheduler_pkg::*;
#(
    parameter int NUM_SLOTS    = 4,
    parameter int X_W          = 10,
    parameter int SCREEN_RIGHT = 639,
    parameter int SPAWN_BASE   = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     frame_tick,
    input  logic                     reset_level,
    input  logic [1:0]               speed,
    input  logic [1:0]               obstacle_count,
    output logic [NUM_SLOTS-1:0]     slot_active,
    output logic [NUM_SLOTS*X_W-1:0] obs_x,
    output logic [NUM_SLOTS*2-1:0]   obs_lane,
    output logic                     spawn_pulse,
    output logic                     busy
);

    localparam int IDX_W = $clog2(NUM_SLOTS);
    localparam int TMR_W = $clog2(SPAWN_BASE + 1);

    sched_state_t      state;
    logic [IDX_W-1:0]  idx;
    logic [TMR_W-1:0]  spawn_timer;
    logic [LANE_W-1:0] lane;
    logic              tick_accept;
    logic [X_W-1:0]    cur_x;
    logic [X_W-1:0]    speed_ext;
    logic              free_found;
    logic [IDX_W-1:0]  free_idx;

    assign tick_accept = frame_tick && !reset_level && (state == ST_IDLE);
    assign speed_ext   = X_W'(speed);
    assign cur_x       = obs_x[idx*X_W +: X_W];

    obstacle_lane_gen u_lane_gen (
        .clk   (clk),
        .reset (reset),
        .step  (tick_accept),
        .lane  (lane)
    );

    // Scan from the top so the lowest free index wins.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!slot_active[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            idx         <= '0;
            spawn_timer <= TMR_W'(SPAWN_BASE);
            slot_active <= '0;
            obs_x       <= '0;
            obs_lane    <= '0;
            spawn_pulse <= 1'b0;
            busy        <= 1'b0;
        end else if (reset_level) begin
            state       <= ST_IDLE;
            idx         <= '0;
            spawn_timer <= TMR_W'(SPAWN_BASE);
            slot_active <= '0;
            obs_x       <= '0;
            obs_lane    <= '0;
            spawn_pulse <= 1'b0;
            busy        <= 1'b0;
        end else begin
            spawn_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (frame_tick) begin
                        state <= ST_MOVE;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                end
                ST_MOVE: begin
                    if (slot_active[idx]) begin
                        if (cur_x >= speed_ext) begin
                            obs_x[idx*X_W +: X_W] <= cur_x - speed_ext;
                        end else begin
                            slot_active[idx]      <= 1'b0;
                            obs_x[idx*X_W +: X_W] <= '0;
                        end
                    end
                    if (idx == IDX_W'(NUM_SLOTS - 1)) begin
                        state <= ST_SPAWN;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                ST_SPAWN: begin
                    // A full pool leaves the timer parked at 0 so the spawn retries next frame.
                    if (obstacle_count != 2'd0) begin
                        if (spawn_timer != '0) begin
                            spawn_timer <= spawn_timer - TMR_W'(1);
                        end else if (free_found) begin
                            slot_active[free_idx]                <= 1'b1;
                            obs_x[free_idx*X_W +: X_W]           <= X_W'(SCREEN_RIGHT);
                            obs_lane[free_idx*LANE_W +: LANE_W]  <= lane;
                            spawn_pulse                          <= 1'b1;
                            spawn_timer <= TMR_W'(SPAWN_BASE >> (obstacle_count - 2'd1));
                        end
                    end
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Self-checking bench for obstacle_scheduler: behavioural pool model feeds a scoreboard
// of per-frame expectations; define OBSTACLE_LANE_RAND_EN to check the LFSR lane build.
module tb_obstacle_scheduler;

    localparam int NS = 4;
    localparam int XW = 10;
    localparam int SR = 639;
    localparam int SB = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic            frame_tick;
    logic            reset_level;
    logic [1:0]      speed;
    logic [1:0]      obstacle_count;
    logic [NS-1:0]   slot_active;
    logic [NS*XW-1:0] obs_x;
    logic [NS*2-1:0] obs_lane;
    logic            spawn_pulse;
    logic            busy;

    always #5 clk = ~clk;

    obstacle_scheduler #(
        .NUM_SLOTS    (NS),
        .X_W          (XW),
        .SCREEN_RIGHT (SR),
        .SPAWN_BASE   (SB)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .frame_tick     (frame_tick),
        .reset_level    (reset_level),
        .speed          (speed),
        .obstacle_count (obstacle_count),
        .slot_active    (slot_active),
        .obs_x          (obs_x),
        .obs_lane       (obs_lane),
        .spawn_pulse    (spawn_pulse),
        .busy           (busy)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic             spawn;
        logic [NS-1:0]    act;
        logic [NS*XW-1:0] x;
        logic [NS*2-1:0]  lane;
    } exp_t;

    exp_t sb_q[$];

    bit         m_act[NS];
    int         m_x[NS];
    int         m_lane[NS];
    int         m_timer;
    logic [7:0] m_gen;

    function automatic void model_clear_pool();
        for (int i = 0; i < NS; i++) begin
            m_act[i]  = 1'b0;
            m_x[i]    = 0;
            m_lane[i] = 0;
        end
        m_timer = SB;
    endfunction

    function automatic void model_step_lane();
`ifdef OBSTACLE_LANE_RAND_EN
        m_gen = {m_gen[6:0], m_gen[7] ^ m_gen[5] ^ m_gen[4] ^ m_gen[3]};
`else
        m_gen = m_gen + 8'd1;
`endif
    endfunction

    // One full frame: model predicts, DUT runs, per-slot x checked at T+2+i, scoreboard at T+NS+2.
    task automatic run_frame(input bit extra_tick, output bit dut_sp, output int slot);
        int   mx[NS];
        int   sp;
        int   cnt;
        int   ln;
        exp_t e;
        logic [NS-1:0]    ea;
        logic [NS*XW-1:0] ex;
        logic [NS*2-1:0]  el;
        sp  = int'(speed);
        cnt = int'(obstacle_count);
        model_step_lane();
        ln = int'(m_gen[1:0]);
        for (int i = 0; i < NS; i++) begin
            if (m_act[i]) begin
                if (m_x[i] >= sp) m_x[i] = m_x[i] - sp;
                else begin
                    m_act[i] = 1'b0;
                    m_x[i]   = 0;
                end
            end
            mx[i] = m_x[i];
        end
        slot = -1;
        e.spawn = 1'b0;
        if (cnt != 0) begin
            if (m_timer != 0) m_timer = m_timer - 1;
            else begin
                for (int i = NS - 1; i >= 0; i--) if (!m_act[i]) slot = i;
                if (slot >= 0) begin
                    m_act[slot]  = 1'b1;
                    m_x[slot]    = SR;
                    m_lane[slot] = ln;
                    e.spawn      = 1'b1;
                    m_timer      = SB >> (cnt - 1);
                end
            end
        end
        for (int i = 0; i < NS; i++) begin
            ea[i]            = m_act[i];
            ex[i*XW +: XW]   = XW'(m_x[i]);
            el[i*2 +: 2]     = 2'(m_lane[i]);
        end
        e.act  = ea;
        e.x    = ex;
        e.lane = el;
        sb_q.push_back(e);

        @(posedge clk);
        #1 frame_tick = 1'b1;
        @(posedge clk);
        #1 frame_tick = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_rise got %0b exp 1", busy);
        end
        for (int i = 0; i < NS; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (obs_x[i*XW +: XW] !== XW'(mx[i])) begin
                errors++;
                $display("FAIL move_x slot %0d got %0d exp %0d", i, obs_x[i*XW +: XW], mx[i]);
            end
            if (extra_tick && i == 0) frame_tick = 1'b1;
            if (extra_tick && i == 1) frame_tick = 1'b0;
        end
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        dut_sp = spawn_pulse;
        checks++;
        if (spawn_pulse !== e.spawn) begin
            errors++;
            $display("FAIL spawn_pulse got %0b exp %0b", spawn_pulse, e.spawn);
        end
        checks++;
        if (slot_active !== e.act) begin
            errors++;
            $display("FAIL slot_active got %b exp %b", slot_active, e.act);
        end
        checks++;
        if (obs_x !== e.x) begin
            errors++;
            $display("FAIL obs_x got %h exp %h", obs_x, e.x);
        end
        checks++;
        if (obs_lane !== e.lane) begin
            errors++;
            $display("FAIL obs_lane got %b exp %b", obs_lane, e.lane);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_fall got %0b exp 0", busy);
        end
        if (extra_tick) begin
            @(posedge clk);
            #1;
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL busy_tick_drop got %0b exp 0", busy);
            end
        end
    endtask

    task automatic test_reset();
        reset          = 1'b0;
        frame_tick     = 1'b0;
        reset_level    = 1'b0;
        speed          = 2'd0;
        obstacle_count = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (slot_active !== '0 || obs_x !== '0 || obs_lane !== '0 || spawn_pulse !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got act=%b x=%h lane=%b sp=%0b busy=%0b exp all 0",
                     slot_active, obs_x, obs_lane, spawn_pulse, busy);
        end
        reset = 1'b1;
        model_clear_pool();
`ifdef OBSTACLE_LANE_RAND_EN
        m_gen = 8'hA5;
`else
        m_gen = 8'h00;
`endif
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || slot_active !== '0) begin
            errors++;
            $display("FAIL reset_release got busy=%0b act=%b exp 0", busy, slot_active);
        end
    endtask

    task automatic test_first_spawn();
        bit sp;
        int sl;
        int nsp;
        obstacle_count = 2'd1;
        speed          = 2'd1;
        nsp            = 0;
        for (int f = 0; f < 64; f++) begin
            run_frame(1'b0, sp, sl);
            if (sp) nsp++;
        end
        checks++;
        if (nsp != 0) begin
            errors++;
            $display("FAIL early_spawn got %0d spawns exp 0", nsp);
        end
        run_frame(1'b0, sp, sl);
        checks++;
        if (sp !== 1'b1 || slot_active !== 4'b0001 || obs_x[XW-1:0] !== 10'd639) begin
            errors++;
            $display("FAIL first_spawn got sp=%0b act=%b x0=%0d exp 1 0001 639", sp, slot_active, obs_x[XW-1:0]);
        end
`ifndef OBSTACLE_LANE_RAND_EN
        checks++;
        if (obs_lane[1:0] !== 2'd1) begin
            errors++;
            $display("FAIL first_lane got %0d exp 1", obs_lane[1:0]);
        end
`endif
    endtask

    task automatic test_movement();
        bit sp;
        int sl;
        int nsp;
        int exp_x[3];
        exp_x[0] = 7;
        exp_x[1] = 4;
        exp_x[2] = 1;
        obstacle_count = 2'd0;
        speed          = 2'd3;
        repeat (209) run_frame(1'b0, sp, sl);
        speed = 2'd2;
        run_frame(1'b0, sp, sl);
        checks++;
        if (obs_x[XW-1:0] !== 10'd10) begin
            errors++;
            $display("FAIL move_setup got %0d exp 10", obs_x[XW-1:0]);
        end
        speed = 2'd3;
        for (int k = 0; k < 3; k++) begin
            run_frame(1'b0, sp, sl);
            checks++;
            if (obs_x[XW-1:0] !== XW'(exp_x[k]) || slot_active[0] !== 1'b1) begin
                errors++;
                $display("FAIL move_step%0d got x=%0d act=%0b exp %0d 1", k, obs_x[XW-1:0], slot_active[0], exp_x[k]);
            end
        end
        run_frame(1'b0, sp, sl);
        checks++;
        if (slot_active[0] !== 1'b0 || obs_x[XW-1:0] !== 10'd0) begin
            errors++;
            $display("FAIL move_free got act=%0b x=%0d exp 0 0", slot_active[0], obs_x[XW-1:0]);
        end
        obstacle_count = 2'd1;
        speed          = 2'd0;
        nsp            = 0;
        repeat (64) begin
            run_frame(1'b0, sp, sl);
            if (sp) nsp++;
        end
        run_frame(1'b0, sp, sl);
        checks++;
        if (nsp != 0 || sp !== 1'b1 || slot_active !== 4'b0001) begin
            errors++;
            $display("FAIL frozen_timer got early=%0d sp=%0b act=%b exp 0 1 0001", nsp, sp, slot_active);
        end
        obstacle_count = 2'd0;
        speed          = 2'd3;
        repeat (212) run_frame(1'b0, sp, sl);
        checks++;
        if (obs_x[XW-1:0] !== 10'd3) begin
            errors++;
            $display("FAIL move_setup3 got %0d exp 3", obs_x[XW-1:0]);
        end
        run_frame(1'b0, sp, sl);
        checks++;
        if (obs_x[XW-1:0] !== 10'd0 || slot_active[0] !== 1'b1) begin
            errors++;
            $display("FAIL move_exact got x=%0d act=%0b exp 0 1", obs_x[XW-1:0], slot_active[0]);
        end
        run_frame(1'b0, sp, sl);
        checks++;
        if (slot_active[0] !== 1'b0) begin
            errors++;
            $display("FAIL move_exact_free got act=%0b exp 0", slot_active[0]);
        end
    endtask

    task automatic test_rate_and_pool_full();
        bit         sp;
        int         sl;
        int         f;
        int         nspawn;
        int         sp_frame[4];
        logic [1:0] sp_lane[4];
        obstacle_count = 2'd3;
        speed          = 2'd3;
        f              = 0;
        nspawn         = 0;
        while (nspawn < 4 && f < 200) begin
            run_frame(1'b0, sp, sl);
            f++;
            if (sp && sl >= 0) begin
                sp_frame[nspawn] = f;
                sp_lane[nspawn]  = obs_lane[sl*2 +: 2];
                nspawn++;
            end
        end
        checks++;
        if (nspawn != 4 || sp_frame[0] != 65) begin
            errors++;
            $display("FAIL rate_first got spawns=%0d frame=%0d exp 4 65", nspawn, sp_frame[0]);
        end
        for (int k = 1; k < 4; k++) begin
            checks++;
            if (nspawn != 4 || sp_frame[k] - sp_frame[k-1] != 17) begin
                errors++;
                $display("FAIL rate_interval%0d got %0d exp 17", k, sp_frame[k] - sp_frame[k-1]);
            end
`ifndef OBSTACLE_LANE_RAND_EN
            checks++;
            if (sp_lane[k] !== sp_lane[k-1] + 2'd1) begin
                errors++;
                $display("FAIL lane_seq%0d got %0d exp %0d", k, sp_lane[k], sp_lane[k-1] + 2'd1);
            end
`endif
        end
        f = 0;
        sp = 1'b0;
        while (!sp && f < 400) begin
            run_frame(1'b0, sp, sl);
            f++;
        end
        checks++;
        if (f != 163 || slot_active !== 4'b1111 || obs_x[XW-1:0] !== 10'd639) begin
            errors++;
            $display("FAIL pool_full_respawn got frames=%0d act=%b x0=%0d exp 163 1111 639", f, slot_active, obs_x[XW-1:0]);
        end
        f = 0;
        sp = 1'b0;
        while (!sp && f < 400) begin
            run_frame(1'b0, sp, sl);
            f++;
        end
        checks++;
        if (f != 17 || obs_x[2*XW-1:XW] !== 10'd639 || obs_x[XW-1:0] !== 10'd588 || slot_active[0] !== 1'b1) begin
            errors++;
            $display("FAIL lowest_free got frames=%0d x1=%0d x0=%0d exp 17 639 588", f, obs_x[2*XW-1:XW], obs_x[XW-1:0]);
        end
    endtask

    task automatic test_reset_level();
        bit sp;
        int sl;
        int nsp;
        int f;
        @(posedge clk);
        #1 frame_tick = 1'b1;
        @(posedge clk);
        #1 frame_tick = 1'b0;
        model_step_lane();
        repeat (2) @(posedge clk);
        #1;
        reset_level = 1'b1;
        frame_tick  = 1'b1;
        @(posedge clk);
        #1;
        reset_level = 1'b0;
        frame_tick  = 1'b0;
        model_clear_pool();
        checks++;
        if (slot_active !== '0 || obs_x !== '0 || obs_lane !== '0 || busy !== 1'b0 || spawn_pulse !== 1'b0) begin
            errors++;
            $display("FAIL reset_level_clear got act=%b x=%h lane=%b busy=%0b sp=%0b exp all 0",
                     slot_active, obs_x, obs_lane, busy, spawn_pulse);
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_level_tick_drop got busy=%0b exp 0", busy);
        end
        obstacle_count = 2'd0;
        speed          = 2'd0;
        nsp            = 0;
        repeat (200) begin
            run_frame(1'b0, sp, sl);
            if (sp) nsp++;
        end
        checks++;
        if (nsp != 0) begin
            errors++;
            $display("FAIL count0_spawn got %0d exp 0", nsp);
        end
        obstacle_count = 2'd1;
        f  = 0;
        sp = 1'b0;
        while (!sp && f < 100) begin
            run_frame(1'b0, sp, sl);
            f++;
        end
        checks++;
        if (f != 65) begin
            errors++;
            $display("FAIL reset_level_timer got spawn frame %0d exp 65", f);
        end
    endtask

    task automatic test_busy_drop_lanes();
        bit sp;
        int sl;
        int nsp;
        int f;
        obstacle_count = 2'd2;
        speed          = 2'd1;
        run_frame(1'b1, sp, sl);
        obstacle_count = 2'd3;
        speed          = 2'd0;
        nsp = 0;
        f   = 0;
        while (nsp < 3 && f < 300) begin
            run_frame(1'b0, sp, sl);
            if (sp) nsp++;
            f++;
        end
        checks++;
        if (nsp != 3) begin
            errors++;
            $display("FAIL lane_spawns got %0d exp 3", nsp);
        end
    endtask

    initial begin
        #5ms;
        errors++;
        $display("FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_spawn();
        test_movement();
        test_rate_and_pool_full();
        test_reset_level();
        test_busy_drop_lanes();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
